// File: rtl/fp_block_packer.sv
// rtl/fp_block_packer.sv - packs decoded sign/exponent/mantissa into IEEE-754 doubles through a small FIFO with block framing
module fp_block_packer #(
  parameter int BLOCK_VALS = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [51:0] s_fp_data_frac,
  input  logic [10:0] s_fp_data_expo,
  input  logic        s_fp_data_sign,
  input  logic        s_fp_valid,
  output logic        s_fp_ready,
  output logic [63:0] m_tdata,
  output logic        m_tlast,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic [31:0] blk_count,
  output logic [63:0] beat_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (BLOCK_VALS > 1) ? $clog2(BLOCK_VALS) : 1;
  localparam logic [CW-1:0] OCC_FULL = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] POS_LAST = PW'(BLOCK_VALS - 1);

  logic [63:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [PW-1:0] pos_q, pos_d;
  logic [31:0]   blk_q, blk_d;
  logic [63:0]   beat_q, beat_d;
  logic          push, pop;

  // Ready and valid are gated by reset so nothing transfers during a reset cycle.
  assign m_tvalid   = !reset && (occ_q != '0);
  assign s_fp_ready = !reset && ((occ_q != OCC_FULL) || m_tready);
  assign m_tlast    = m_tvalid && (pos_q == POS_LAST);
  assign m_tdata    = mem_q[rd_ptr_q];
  assign blk_count  = blk_q;
  assign beat_count = beat_q;

  assign push = s_fp_valid && s_fp_ready;
  assign pop  = m_tvalid && m_tready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    pos_d    = pos_q;
    blk_d    = blk_q;
    beat_d   = beat_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      beat_d   = beat_q + 64'd1;
      pos_d    = (pos_q == POS_LAST) ? '0 : pos_q + PW'(1);
      if (m_tlast) begin
        blk_d = blk_q + 32'd1;
      end
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + CW'(1);
      2'b01:   occ_d = occ_q - CW'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      pos_q    <= '0;
      blk_q    <= '0;
      beat_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      pos_q    <= pos_d;
      blk_q    <= blk_d;
      beat_q   <= beat_d;
    end
  end

  // Storage is unreset; contents are only observed while m_tvalid is high.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {s_fp_data_sign, s_fp_data_expo, s_fp_data_frac};
    end
  end

endmodule

// File: tb/tb_fp_block_packer.sv
// tb/tb_fp_block_packer.sv - self-checking bench for fp_block_packer
module tb_fp_block_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic [51:0] s_fp_data_frac;
  logic [10:0] s_fp_data_expo;
  logic        s_fp_data_sign;
  logic        s_fp_valid;
  logic        s_fp_ready;
  logic [63:0] m_tdata;
  logic        m_tlast;
  logic        m_tvalid;
  logic        m_tready;
  logic [31:0] blk_count;
  logic [63:0] beat_count;

  int n_vec = 0;
  int n_err = 0;

  fp_block_packer #(.BLOCK_VALS(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .s_fp_data_frac(s_fp_data_frac), .s_fp_data_expo(s_fp_data_expo),
    .s_fp_data_sign(s_fp_data_sign), .s_fp_valid(s_fp_valid), .s_fp_ready(s_fp_ready),
    .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .blk_count(blk_count), .beat_count(beat_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sign;
    logic [10:0] expo;
    logic [51:0] frac;
    logic [63:0] exp_data;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive64(input logic [63:0] v);
    s_fp_data_sign = v[63];
    s_fp_data_expo = v[62:52];
    s_fp_data_frac = v[51:0];
  endtask

  function automatic logic [63:0] val(input int n);
    return 64'(n) * 64'h9E37_79B9_7F4A_7C15 + 64'h0123_4567_89AB_CDEF;
  endfunction

  // Scoreboard and reference counters, sampled mid-cycle.
  logic [63:0] sb[$];
  logic [63:0] mdl_beats, prev_data;
  logic [31:0] mdl_blks;
  int          mdl_pos, n_acc;
  logic        prev_stall, prev_last;

  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      mdl_pos = 0; mdl_beats = 0; mdl_blks = 0; n_acc = 0; prev_stall = 0;
    end else begin
      chk("sb_beat_count", beat_count, mdl_beats);
      chk("sb_blk_count", 64'(blk_count), 64'(mdl_blks));
      if (prev_stall) begin
        chk("stall_tvalid", 64'(m_tvalid), 64'd1);
        chk("stall_tdata", m_tdata, prev_data);
        chk("stall_tlast", 64'(m_tlast), 64'(prev_last));
      end
      if (m_tvalid && m_tready) begin
        if (sb.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL sb_underflow: got beat %h expected no beat", m_tdata);
        end else begin
          chk("sb_tdata", m_tdata, sb.pop_front());
        end
        chk("sb_tlast", 64'(m_tlast), 64'(mdl_pos == 15));
        if (m_tlast) mdl_blks = mdl_blks + 1;
        mdl_pos = (mdl_pos == 15) ? 0 : mdl_pos + 1;
        mdl_beats = mdl_beats + 1;
      end
      if (s_fp_valid && s_fp_ready) begin
        sb.push_back({s_fp_data_sign, s_fp_data_expo, s_fp_data_frac});
        n_acc++;
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
      prev_last  = m_tlast;
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    s_fp_valid = 1'b1;
    m_tready = 1'b1;
    step();
    chk("rst_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_tlast", 64'(m_tlast), 64'd0);
    chk("rst_ready", 64'(s_fp_ready), 64'd0);
    chk("rst_blk", 64'(blk_count), 64'd0);
    chk("rst_beat", beat_count, 64'd0);
    reset = 1'b0;
    s_fp_valid = 1'b0;
    m_tready = 1'b0;
    #1;
    chk("post_rst_ready", 64'(s_fp_ready), 64'd1);
    chk("post_rst_tvalid", 64'(m_tvalid), 64'd0);
  endtask

  task automatic drain();
    s_fp_valid = 1'b0;
    m_tready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (!m_tvalid) break;
      step();
    end
    chk("drain_empty", 64'(m_tvalid), 64'd0);
  endtask

  vec_t tbl[10];

  initial begin
    tbl[0] = '{1'b0, 11'h3FF, 52'h0,             64'h3FF0_0000_0000_0000};
    tbl[1] = '{1'b1, 11'h400, 52'h0,             64'hC000_0000_0000_0000};
    tbl[2] = '{1'b0, 11'h7FF, 52'h0,             64'h7FF0_0000_0000_0000};
    tbl[3] = '{1'b1, 11'h7FF, 52'h0,             64'hFFF0_0000_0000_0000};
    tbl[4] = '{1'b0, 11'h7FF, 52'h8_0000_0000_0000, 64'h7FF8_0000_0000_0000};
    tbl[5] = '{1'b1, 11'h000, 52'h0,             64'h8000_0000_0000_0000};
    tbl[6] = '{1'b0, 11'h000, 52'h1,             64'h0000_0000_0000_0001};
    tbl[7] = '{1'b0, 11'h7FE, 52'hF_FFFF_FFFF_FFFF, 64'h7FEF_FFFF_FFFF_FFFF};
    tbl[8] = '{1'b0, 11'h3FD, 52'h5_5555_5555_5555, 64'h3FD5_5555_5555_5555};
    tbl[9] = '{1'b0, 11'h400, 52'h9_21FB_5444_2D18, 64'h4009_21FB_5444_2D18};

    reset = 1'b1; s_fp_valid = 1'b0; m_tready = 1'b0; drive64(64'd0);
    step();
    do_reset();

    // Single value, 1-cycle latency.
    m_tready = 1'b1;
    s_fp_data_sign = 1'b1; s_fp_data_expo = 11'h3FF; s_fp_data_frac = 52'h0;
    s_fp_valid = 1'b1;
    step();
    s_fp_valid = 1'b0;
    chk("single_tvalid", 64'(m_tvalid), 64'd1);
    chk("single_tdata", m_tdata, 64'hBFF0_0000_0000_0000);
    chk("single_tlast", 64'(m_tlast), 64'd0);
    step();
    chk("single_beat", beat_count, 64'd1);
    chk("single_empty", 64'(m_tvalid), 64'd0);

    // Packing table including NaN/Inf/zero/denormal.
    do_reset();
    m_tready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      s_fp_data_sign = tbl[i].sign;
      s_fp_data_expo = tbl[i].expo;
      s_fp_data_frac = tbl[i].frac;
      s_fp_valid = 1'b1;
      step();
      s_fp_valid = 1'b0;
      chk($sformatf("tbl%0d_tdata", i), m_tdata, tbl[i].exp_data);
      chk($sformatf("tbl%0d_tvalid", i), 64'(m_tvalid), 64'd1);
      step();
    end

    // 32 back-to-back values, two blocks.
    do_reset();
    m_tready = 1'b1;
    for (int j = 0; j < 32; j++) begin
      drive64(val(j));
      s_fp_valid = 1'b1;
      chk("stream_ready", 64'(s_fp_ready), 64'd1);
      step();
      chk("stream_tdata", m_tdata, val(j));
      chk($sformatf("stream_tlast%0d", j), 64'(m_tlast), 64'(j == 15 || j == 31));
    end
    s_fp_valid = 1'b0;
    step();
    chk("stream_blk", 64'(blk_count), 64'd2);
    chk("stream_beat", beat_count, 64'd32);

    // Backpressure: 5 offered into a 4-deep FIFO.
    do_reset();
    m_tready = 1'b0;
    for (int j = 0; j < 5; j++) begin
      drive64(val(50 + j));
      s_fp_valid = 1'b1;
      chk($sformatf("bp_ready%0d", j), 64'(s_fp_ready), 64'(j < 4));
      step();
      chk("bp_head", m_tdata, val(50));
    end
    for (int j = 0; j < 3; j++) begin
      step();
      chk("bp_hold_tdata", m_tdata, val(50));
      chk("bp_hold_ready", 64'(s_fp_ready), 64'd0);
    end
    m_tready = 1'b1;
    #1;
    chk("bp_full_pop_ready", 64'(s_fp_ready), 64'd1);
    step();
    s_fp_valid = 1'b0;
    chk("bp_out1", m_tdata, val(51));
    for (int k = 2; k < 5; k++) begin
      step();
      chk($sformatf("bp_out%0d", k), m_tdata, val(50 + k));
    end
    step();
    chk("bp_done", 64'(m_tvalid), 64'd0);

    // Full FIFO with simultaneous push and pop.
    do_reset();
    m_tready = 1'b0;
    for (int j = 0; j < 4; j++) begin
      drive64(val(100 + j));
      s_fp_valid = 1'b1;
      step();
    end
    m_tready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      drive64(val(104 + k));
      #1;
      chk("full_ready", 64'(s_fp_ready), 64'd1);
      step();
      chk("full_head", m_tdata, val(101 + k));
    end
    m_tready = 1'b0;
    #1;
    chk("full_still_full", 64'(s_fp_ready), 64'd0);
    drain();

    // Reset mid-block.
    do_reset();
    m_tready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      drive64(val(200 + j));
      s_fp_valid = 1'b1;
      step();
    end
    chk("mid_beat7", beat_count, 64'd7);
    reset = 1'b1;
    s_fp_valid = 1'b0;
    step();
    chk("mid_rst_tvalid", 64'(m_tvalid), 64'd0);
    chk("mid_rst_ready", 64'(s_fp_ready), 64'd0);
    chk("mid_rst_blk", 64'(blk_count), 64'd0);
    chk("mid_rst_beat", beat_count, 64'd0);
    reset = 1'b0;
    for (int j = 0; j < 16; j++) begin
      drive64(val(300 + j));
      s_fp_valid = 1'b1;
      step();
      chk("mid_tdata", m_tdata, val(300 + j));
      chk($sformatf("mid_tlast%0d", j), 64'(m_tlast), 64'(j == 15));
    end
    s_fp_valid = 1'b0;
    step();
    chk("mid_blk", 64'(blk_count), 64'd1);
    chk("mid_beat", beat_count, 64'd16);

    // Random traffic against the scoreboard.
    do_reset();
    for (int i = 0; i < 8740; i++) begin
      s_fp_valid = ($urandom_range(0, 3) != 0);
      m_tready = ($urandom_range(0, 2) != 0);
      drive64({$urandom, $urandom});
      step();
    end
    s_fp_valid = 1'b0;
    m_tready = 1'b0;
    #1;
    chk("rand_beats", beat_count, 64'(n_acc - sb.size()));
    drain();
    #1;
    chk("rand_sb_empty", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fp_block_packer.md
FP_BLOCK_PACKER -- requirements
Module: fp_block_packer

Interface
REQ-001 SHALL have parameter BLOCK_VALS, default 16: number of values per decoded block; m_tlast marks the last one; legal range 1..256.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: buffer entries; power of two, at least 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port s_fp_data_frac, input, 52 bits: decoded mantissa.
REQ-006 SHALL have port s_fp_data_expo, input, 11 bits: decoded biased exponent.
REQ-007 SHALL have port s_fp_data_sign, input, 1 bit: decoded sign.
REQ-008 SHALL have port s_fp_valid, input, 1 bit: the decoder offers a value.
REQ-009 SHALL have port s_fp_ready, output, 1 bit: the block accepts the offered value.
REQ-010 SHALL have port m_tdata, output, 64 bits: packed IEEE-754 double.
REQ-011 SHALL have port m_tlast, output, 1 bit: last value of a block.
REQ-012 SHALL have port m_tvalid, output, 1 bit: output beat valid.
REQ-013 SHALL have port m_tready, input, 1 bit: downstream accepts the beat.
REQ-014 SHALL have port blk_count, output, 32 bits: number of complete blocks emitted.
REQ-015 SHALL have port beat_count, output, 64 bits: number of output beats accepted.

Function
REQ-016 SHALL pack each accepted input as m_tdata = {sign, expo, frac}, i.e. sign in bit 63, expo in bits 62:52, frac in bits 51:0, with no arithmetic change.
REQ-017 SHALL complete an input transfer only on a cycle with s_fp_valid=1 and s_fp_ready=1; that value is written into the FIFO.
REQ-018 SHALL drive s_fp_ready = 1 when the FIFO is not full, and also when it is full but an output beat pops in the same cycle; s_fp_ready is combinational from FIFO occupancy and m_tready.
REQ-019 SHALL, when the FIFO is empty, present an accepted value on m_tdata with m_tvalid=1 on the cycle after acceptance: latency is 1 cycle, with no same-cycle bypass.
REQ-020 SHALL complete an output transfer only on a cycle with m_tvalid=1 and m_tready=1.
REQ-021 SHALL keep m_tdata, m_tlast and m_tvalid stable while m_tvalid=1 and m_tready=0.
REQ-022 SHALL sustain one push and one pop in the same cycle at any occupancy, leaving occupancy unchanged.
REQ-023 SHALL use FIFO pointers of log2(FIFO_DEPTH) bits that wrap modulo FIFO_DEPTH, plus an occupancy counter of 0..FIFO_DEPTH.
REQ-024 SHALL drive m_tvalid = 1 exactly when occupancy is greater than 0.
REQ-025 SHALL keep a position counter pos (0..BLOCK_VALS-1) that increments on each output transfer and wraps to 0 after BLOCK_VALS-1.
REQ-026 SHALL drive m_tlast = 1 exactly when m_tvalid=1 and pos = BLOCK_VALS-1; when BLOCK_VALS=1 every beat has m_tlast=1.
REQ-027 SHALL increment blk_count by 1 on each output transfer with m_tlast=1; blk_count wraps from 2^32-1 to 0.
REQ-028 SHALL increment beat_count by 1 on each output transfer; beat_count wraps modulo 2^64.
REQ-029 SHALL drop no input value, duplicate no output value, and preserve input order under any s_fp_valid/m_tready pattern.
REQ-030 SHALL pass NaN, Inf, zero and denormal encodings through bit-exact, with no special handling.

Reset
REQ-031 SHALL, on a clock edge with reset=1, set occupancy, both pointers, pos, blk_count and beat_count to 0.
REQ-032 SHALL hold m_tvalid=0, m_tlast=0 and s_fp_ready=0 while reset=1.
REQ-033 SHALL discard FIFO contents on a reset asserted mid-block, so the next accepted value after reset is position 0.
REQ-034 SHALL treat m_tdata as don't-care while m_tvalid=0, so FIFO storage needs no reset.

Verification
REQ-035 SHALL be tested with a single value: sign=1, expo=0x3FF, frac=0, m_tready=1 -> the next cycle m_tdata=0xBFF0000000000000, m_tvalid=1, m_tlast=0, beat_count=1.
REQ-036 SHALL be tested with 32 values streamed back-to-back, m_tready=1 always -> m_tlast=1 on beats 16 and 32 only, blk_count=2, beat_count=32, throughput 1 beat/cycle.
REQ-037 SHALL be tested with m_tready=0 while 5 values are offered and FIFO_DEPTH=4 -> 4 accepted, then s_fp_ready=0; m_tdata stays equal to value 0 until m_tready=1; all 5 values emerge in order.
REQ-038 SHALL be tested with FIFO full, s_fp_valid=1 and m_tready=1 for 10 cycles -> one push and one pop per cycle, occupancy stays 4, no loss.
REQ-039 SHALL be tested with reset=1 for 1 cycle after 7 beats of a block, then 16 values -> blk_count=0 and beat_count=0 right after reset; m_tlast on the 16th post-reset beat; blk_count=1.
REQ-040 SHALL be tested with random m_tready and s_fp_valid over 8740 cycles against a scoreboard -> bit-exact in-order match, and beat_count equals the number of accepted inputs minus final occupancy.
